// File: rtl/shift_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_stage_if
// Description : Valid/ready operand and result channels of the shift stage.
//               The master modport is the upstream/downstream environment side.
//               The slave modport is the shift stage side.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_cnt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_zero;

    modport master (
        output in_valid, in_data, in_cnt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_cnt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_zero
    );
endinterface
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_stage
// Description : Two-stage valid/ready pipelined 16-bit shifter.
//               S1 registers the operands. S2 registers the result and zero flag.
//               Op encoding: 00 rol, 01 sll, 10 ror, 11 srl.
//               Macro SHIFT_STAGE_ROTATE_EN enables the rotate operations.
//               When it is undefined, op 00 acts as sll and op 10 acts as srl.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_stage (
    input  wire          clk,
    input  wire          rst,
    input  wire          flush,
    shift_stage_if.slave bus
);

    // Stage 1 operand registers
    logic        r_s1_valid;
    logic [15:0] r_s1_data;
    logic [3:0]  r_s1_cnt;
    logic [1:0]  r_s1_op;

    // Stage 2 result registers
    logic        r_s2_valid;
    logic [15:0] r_s2_data;
    logic        r_s2_zero;

    // Handshake wires
    logic        w_s2_free;
    logic        w_s1_adv;
    logic        w_in_ready;
    logic        w_in_fire;

    // Shifter wires
    logic [15:0] w_sll;
    logic [15:0] w_srl;
    logic [15:0] w_result;

    // S2 can take a new result when it is empty or is being drained this cycle.
    assign w_s2_free  = !r_s2_valid || bus.out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_free;
    // Readiness depends only on pipeline state, never on in_valid.
    assign w_in_ready = !r_s1_valid || w_s2_free;
    assign w_in_fire  = bus.in_valid && w_in_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_data  = r_s2_data;
    assign bus.out_zero  = r_s2_zero;

    assign w_sll = r_s1_data << r_s1_cnt;
    assign w_srl = r_s1_data >> r_s1_cnt;

`ifdef SHIFT_STAGE_ROTATE_EN
    logic [4:0]  w_cnt_inv;
    logic [15:0] w_rol;
    logic [15:0] w_ror;

    // Shifting by 16 yields zero, so cnt=0 degenerates to the operand itself.
    assign w_cnt_inv = 5'd16 - {1'b0, r_s1_cnt};
    assign w_rol     = (r_s1_data << r_s1_cnt) | (r_s1_data >> w_cnt_inv);
    assign w_ror     = (r_s1_data >> r_s1_cnt) | (r_s1_data << w_cnt_inv);
`endif

    // Select the shift result for the operation held in S1.
    always_comb begin
        w_result = w_sll;
        case (r_s1_op)
`ifdef SHIFT_STAGE_ROTATE_EN
            2'b00:   w_result = w_rol;
            2'b10:   w_result = w_ror;
`else
            2'b00:   w_result = w_sll;
            2'b10:   w_result = w_srl;
`endif
            2'b01:   w_result = w_sll;
            2'b11:   w_result = w_srl;
            default: w_result = w_sll;
        endcase
    end

    // Pipeline valid bits: flush overrides every transfer in the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_in_fire || (r_s1_valid && !w_s1_adv);
            r_s2_valid <= w_s1_adv  || (r_s2_valid && !bus.out_ready);
        end
    end

    // S1 operand capture on every accepted input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_data <= 16'h0000;
            r_s1_cnt  <= 4'd0;
            r_s1_op   <= 2'b00;
        end else if (w_in_fire) begin
            r_s1_data <= bus.in_data;
            r_s1_cnt  <= bus.in_cnt;
            r_s1_op   <= bus.in_op;
        end
    end

    // S2 result capture. This holds steady while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_data <= 16'h0000;
            r_s2_zero <= 1'b1;
        end else if (w_s1_adv) begin
            r_s2_data <= w_result;
            r_s2_zero <= (w_result == 16'h0000);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_stage
// Description : Directed self-checking bench for shift_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_stage;

    logic clk;
    logic rst;
    logic flush;
    int   n_checks;
    int   n_passed;
    int   n_failed;

    shift_stage_if bus ();

    shift_stage dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_passed++;
        else begin
            n_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] c, input logic [1:0] o);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_cnt   = c;
        bus.in_op    = o;
    endtask

    task automatic run_op(input string tag, input logic [15:0] d, input logic [3:0] c,
                          input logic [1:0] o, input logic [15:0] exp);
        @(negedge clk);
        check({tag, " rdy"}, {15'd0, bus.in_ready}, 16'd1);
        drive(1'b1, d, c, o);
        @(negedge clk);
        drive(1'b0, 16'h0000, 4'd0, 2'b00);
        check({tag, " early"}, {15'd0, bus.out_valid}, 16'd0);
        @(negedge clk);
        check({tag, " vld"}, {15'd0, bus.out_valid}, 16'd1);
        check({tag, " data"}, bus.out_data, exp);
        check({tag, " zero"}, {15'd0, bus.out_zero}, {15'd0, exp == 16'h0000});
    endtask

    initial begin
        n_checks = 0;
        n_passed = 0;
        n_failed = 0;
        rst   = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 16'h0000, 4'd0, 2'b00);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst vld", {15'd0, bus.out_valid}, 16'd0);
        check("rst rdy", {15'd0, bus.in_ready}, 16'd1);
        check("rst data", bus.out_data, 16'h0000);
        check("rst zero", {15'd0, bus.out_zero}, 16'd1);
        rst = 1'b0;

        // Basic ops, data 8001 cnt 1
        run_op("sll", 16'h8001, 4'd1, 2'b01, 16'h0002);
        run_op("srl", 16'h8001, 4'd1, 2'b11, 16'h4000);
`ifdef SHIFT_STAGE_ROTATE_EN
        run_op("rol", 16'h8001, 4'd1, 2'b00, 16'h0003);
        run_op("ror", 16'h8001, 4'd1, 2'b10, 16'hC000);
        run_op("rol4", 16'h1234, 4'd4, 2'b00, 16'h2341);
        run_op("ror15", 16'h8001, 4'd15, 2'b10, 16'h0003);
`else
        run_op("op00", 16'h8001, 4'd1, 2'b00, 16'h0002);
        run_op("op10", 16'h8001, 4'd1, 2'b10, 16'h4000);
`endif

        // Boundaries
        run_op("cnt0 op00", 16'hA5A5, 4'd0, 2'b00, 16'hA5A5);
        run_op("cnt0 op01", 16'hA5A5, 4'd0, 2'b01, 16'hA5A5);
        run_op("cnt0 op10", 16'hA5A5, 4'd0, 2'b10, 16'hA5A5);
        run_op("cnt0 op11", 16'hA5A5, 4'd0, 2'b11, 16'hA5A5);
        run_op("sll15", 16'hFFFF, 4'd15, 2'b01, 16'h8000);
        run_op("srl to0", 16'h0001, 4'd1, 2'b11, 16'h0000);
        run_op("srl15", 16'hFFFF, 4'd15, 2'b11, 16'h0001);

        // Back-to-back throughput
        @(negedge clk); drive(1'b1, 16'h0101, 4'd2, 2'b01);
        @(negedge clk); check("tp early", {15'd0, bus.out_valid}, 16'd0);
        drive(1'b1, 16'h0F00, 4'd4, 2'b11);
        @(negedge clk); check("tp0", bus.out_data, 16'h0404);
        drive(1'b1, 16'h0003, 4'd8, 2'b01);
        @(negedge clk); check("tp1", bus.out_data, 16'h00F0);
        drive(1'b0, 16'h0000, 4'd0, 2'b00);
        @(negedge clk); check("tp2", bus.out_data, 16'h0300);
        @(negedge clk); check("tp idle", {15'd0, bus.out_valid}, 16'd0);

        // Backpressure: four sll-by-1 operations
        bus.out_ready = 1'b0;
        @(negedge clk); drive(1'b1, 16'h0011, 4'd1, 2'b01);
        @(negedge clk);
        check("bp rdy1", {15'd0, bus.in_ready}, 16'd1);
        drive(1'b1, 16'h0022, 4'd1, 2'b01);
        @(negedge clk);
        check("bp rdy0", {15'd0, bus.in_ready}, 16'd0);
        check("bp vld", {15'd0, bus.out_valid}, 16'd1);
        check("bp d0", bus.out_data, 16'h0022);
        drive(1'b1, 16'h0033, 4'd1, 2'b01);
        @(negedge clk);
        check("bp hold", bus.out_data, 16'h0022);
        check("bp rdy0b", {15'd0, bus.in_ready}, 16'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp d1", bus.out_data, 16'h0044);
        drive(1'b1, 16'h0044, 4'd1, 2'b01);
        @(negedge clk);
        check("bp d2", bus.out_data, 16'h0066);
        drive(1'b0, 16'h0000, 4'd0, 2'b00);
        @(negedge clk);
        check("bp d3", bus.out_data, 16'h0088);
        check("bp d3 vld", {15'd0, bus.out_valid}, 16'd1);
        @(negedge clk);
        check("bp empty", {15'd0, bus.out_valid}, 16'd0);

        // Flush with both stages full and an input on offer
        bus.out_ready = 1'b0;
        @(negedge clk); drive(1'b1, 16'h0100, 4'd1, 2'b01);
        @(negedge clk); drive(1'b1, 16'h0200, 4'd1, 2'b01);
        @(negedge clk);
        check("fl full", {15'd0, bus.out_valid}, 16'd1);
        drive(1'b1, 16'h7777, 4'd0, 2'b01);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 16'h0000, 4'd0, 2'b00);
        check("fl vld", {15'd0, bus.out_valid}, 16'd0);
        check("fl rdy", {15'd0, bus.in_ready}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("fl drop", {15'd0, bus.out_valid}, 16'd0);
        end

        // Asynchronous reset mid-stream
        bus.out_ready = 1'b0;
        @(negedge clk); drive(1'b1, 16'h00F0, 4'd1, 2'b01);
        @(negedge clk); drive(1'b1, 16'h0F00, 4'd1, 2'b01);
        @(negedge clk);
        drive(1'b0, 16'h0000, 4'd0, 2'b00);
        check("mr full", {15'd0, bus.out_valid}, 16'd1);
        #2 rst = 1'b1;
        #1;
        check("mr vld", {15'd0, bus.out_valid}, 16'd0);
        check("mr rdy", {15'd0, bus.in_ready}, 16'd1);
        check("mr data", bus.out_data, 16'h0000);
        check("mr zero", {15'd0, bus.out_zero}, 16'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        run_op("post rst", 16'h1111, 4'd2, 2'b01, 16'h4444);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_stage.md
SHIFT_STAGE -- requirements
Module: shift_stage

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, with the ports listed below.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 flush  input  1  synchronous squash of all in-flight operations.
REQ-005 in_valid  input  1  upstream offers an operation.
REQ-006 in_ready  output  1  stage can accept an operation this cycle.
REQ-007 in_data  input  16  operand to shift.
REQ-008 in_cnt  input  4  shift amount, 0..15.
REQ-009 in_op  input  2  00 rol, 01 sll, 10 ror, 11 srl.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_data  output  16  shifted result.
REQ-013 out_zero  output  1  out_data equals 16'h0000.

Function
REQ-014 The module SHALL be a 2-stage pipeline: S1 holds the registered operands {data, cnt, op}; S2 holds the registered result and zero flag.
REQ-015 An input transfer SHALL occur on a clock edge when in_valid and in_ready are both 1; the operands load into S1 and S1 becomes valid.
REQ-016 An output transfer SHALL occur on a clock edge when out_valid and out_ready are both 1.
REQ-017 The S1 result SHALL be computed combinationally from the S1 register and loaded into S2 when S1 is valid and S2 is empty or draining (s2_free = !s2_valid | out_ready).
REQ-018 in_ready SHALL be asserted when S1 is empty or S1 advances this cycle (in_ready = !s1_valid | s2_free); in_ready SHALL NOT depend on in_valid.
REQ-019 Latency SHALL be 2 cycles: an operation accepted at edge N SHALL present out_valid after edge N+1, with no stall.
REQ-020 Throughput SHALL be one operation per cycle while out_ready stays 1.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_zero SHALL hold stable.
REQ-022 Shift semantics: sll/srl SHALL fill vacated bits with 0; rol/ror SHALL wrap bits end-around; cnt=0 SHALL return in_data unchanged for every op.
REQ-023 srl SHALL be logical, so bit 15 of the result is 0 when cnt is nonzero.
REQ-024 out_zero SHALL equal (out_data == 0) and SHALL be registered alongside out_data in S2.
REQ-025 When flush=1 at an edge, s1_valid and s2_valid SHALL both clear and any input offered on that edge SHALL be dropped; flush SHALL take priority over all transfers.
REQ-026 Data registers SHALL NOT need to clear on flush; only the valid bits SHALL clear.

Reset
REQ-027 While rst=1, s1_valid and s2_valid SHALL be 0 immediately (asynchronously), so out_valid=0, out_data=16'h0000, out_zero=1, and in_ready=1.
REQ-028 Reset asserted mid-operation SHALL discard every in-flight operation; after rst deasserts, the first accepted operation SHALL follow REQ-019.

Configuration
REQ-029 The macro SHIFT_STAGE_ROTATE_EN SHALL control support for the rotate operations.
REQ-030 With SHIFT_STAGE_ROTATE_EN defined, op 00 SHALL perform rol and op 10 SHALL perform ror.
REQ-031 Without SHIFT_STAGE_ROTATE_EN, op 00 SHALL perform sll and op 10 SHALL perform srl, and the rotate logic SHALL be absent.

Verification
REQ-032 Reset check: assert rst mid-stream -> out_valid=0 and in_ready=1 immediately; out_data=0000 and out_zero=1.
REQ-033 Basic ops check: data=8001, cnt=1; sll -> 0002; srl -> 4000; with ROTATE_EN, rol -> 0003 and ror -> C000; each appears 2 cycles after acceptance.
REQ-034 Backpressure check: stream 4 operations with out_ready=0 -> in_ready drops after 2 accepts; out_data holds; releasing out_ready drains all 4 in order with none lost or duplicated.
REQ-035 Flush check: S1 and S2 full and in_valid=1, pulse flush -> next cycle out_valid=0; the offered input never appears at the output.
REQ-036 Boundary check: cnt=0 with data=A5A5 -> A5A5; sll data=FFFF, cnt=15 -> 8000; srl data=0001, cnt=1 -> 0000 with out_zero=1.
